// File: rtl/naive_wb_dma_pkg.sv
// Shared definitions for the DMA load/write-back paths: FSM state encoding
// and helpers that derive byte counts from word and bus widths.
package naive_wb_dma_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Number of bus beats needed to move one word.
  function automatic int bytes_per_word(input int word_width, input int bus_width);
    return word_width / bus_width;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/naive_wb_dma_if.sv
// Result-word handshake plus byte-wide memory write bus of the write-back DMA.
// result_*: a word transfers on every rising clk edge where result_valid and
// result_ready are both high; the source holds data/valid until then, and
// valid seen while ready is low is never consumed. mem_*: write-only bus,
// the memory accepts every cycle with mem_wr_en high, no back-pressure.
interface naive_wb_dma_if #(
  parameter int WORD_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 8,
  parameter int BUS_ADDR_WIDTH = 32
);

  logic [WORD_WIDTH-1:0]     result_data;
  logic                      result_valid;
  logic                      result_ready;
  logic [BUS_DATA_WIDTH-1:0] mem_data_wr;
  logic [BUS_ADDR_WIDTH-1:0] mem_addr;
  logic                      mem_wr_en;

  modport master (
    input  result_data,
    input  result_valid,
    output result_ready,
    output mem_data_wr,
    output mem_addr,
    output mem_wr_en
  );

  modport slave (
    output result_data,
    output result_valid,
    input  result_ready,
    input  mem_data_wr,
    input  mem_addr,
    input  mem_wr_en
  );

endinterface

// File: rtl/naive_wb_dma_word_serializer.sv
// Turns one result word into a big-endian stream of bus-width beats.
// byte_out is the registered beat currently on the bus; byte_cnt is its index.
module naive_wb_dma_word_serializer
  import naive_wb_dma_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic                      emit,
  input  logic                      clear,
  input  logic [WORD_WIDTH-1:0]     word_in,
  output logic [BUS_DATA_WIDTH-1:0] byte_out,
  output logic                      last_byte,
  output logic                      last_byte_next
);

  localparam int BYTES = bytes_per_word(WORD_WIDTH, BUS_DATA_WIDTH);
  localparam int CNT_W = cnt_width(BYTES);

  logic [WORD_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      byte_cnt;

  // shift_reg always holds the not-yet-emitted bytes, MSB-aligned, so the
  // next beat is its top slice and byte_out holds when nothing is emitted.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      byte_out  <= '0;
      byte_cnt  <= '0;
    end else if (load) begin
      byte_out  <= word_in[WORD_WIDTH-1 -: BUS_DATA_WIDTH];
      shift_reg <= word_in << BUS_DATA_WIDTH;
      byte_cnt  <= '0;
    end else if (emit) begin
      byte_out  <= shift_reg[WORD_WIDTH-1 -: BUS_DATA_WIDTH];
      shift_reg <= shift_reg << BUS_DATA_WIDTH;
      byte_cnt  <= byte_cnt + CNT_W'(1);
    end else if (clear) begin
      byte_cnt  <= '0;
    end
  end

  assign last_byte = (byte_cnt == CNT_W'(BYTES - 1));

  // Whether the beat on the bus next cycle is the final one of its word.
  always_comb begin
    if (load) begin
      last_byte_next = (BYTES == 1);
    end else if (emit) begin
      last_byte_next = (byte_cnt == CNT_W'(BYTES - 2));
    end else if (clear) begin
      last_byte_next = (BYTES == 1);
    end else begin
      last_byte_next = last_byte;
    end
  end

endmodule

// File: rtl/naive_wb_dma.sv
// Write-back DMA: accepts NUM_WORDS result words and writes them MSB-byte
// first to consecutive byte addresses, then holds done until enable drops.
module naive_wb_dma
  import naive_wb_dma_pkg::*;
#(
  parameter int WORD_WIDTH     = 32,
  parameter int BUS_DATA_WIDTH = 8,
  parameter int BUS_ADDR_WIDTH = 32,
  parameter int NUM_WORDS      = 4,
  parameter int NUM_WORDS_BIT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en_wb_dma,
  input  logic [BUS_ADDR_WIDTH-1:0] wb_base_address,
  output logic                      done_wb_dma,
  output logic                      busy_wb_dma,
  output logic [1:0]                state_dbg,
  naive_wb_dma_if.master            bus
);

  logic [1:0]                state;
  logic [1:0]                state_nxt;
  logic [NUM_WORDS_BIT-1:0]  word_cnt;
  logic [NUM_WORDS_BIT-1:0]  word_cnt_nxt;
  logic [BUS_ADDR_WIDTH-1:0] addr_reg;
  logic                      accept;
  logic                      last_word;
  logic                      load;
  logic                      emit;
  logic                      clear;
  logic                      word_done;
  logic                      write_nxt;
  logic                      ready_nxt;
  logic                      last_byte;
  logic                      last_byte_next;
  logic [BUS_DATA_WIDTH-1:0] byte_out;

  assign accept    = bus.result_valid && bus.result_ready;
  assign last_word = (word_cnt == NUM_WORDS_BIT'(NUM_WORDS - 1));
  assign state_dbg = state;

  naive_wb_dma_word_serializer #(
    .WORD_WIDTH     (WORD_WIDTH),
    .BUS_DATA_WIDTH (BUS_DATA_WIDTH)
  ) u_serializer (
    .clk            (clk),
    .rst            (rst),
    .load           (load),
    .emit           (emit),
    .clear          (clear),
    .word_in        (bus.result_data),
    .byte_out       (byte_out),
    .last_byte      (last_byte),
    .last_byte_next (last_byte_next)
  );

  // Dropping enable wins over everything else in FETCH and WRITE.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    emit      = 1'b0;
    clear     = 1'b0;
    word_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en_wb_dma) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (!en_wb_dma) begin
          state_nxt = ST_IDLE;
          clear     = 1'b1;
        end else if (accept) begin
          state_nxt = ST_WRITE;
          load      = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!en_wb_dma) begin
          state_nxt = ST_IDLE;
          clear     = 1'b1;
        end else if (!last_byte) begin
          emit = 1'b1;
        end else begin
          word_done = 1'b1;
          if (last_word) begin
            state_nxt = ST_DONE;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            state_nxt = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        if (!en_wb_dma) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    word_cnt_nxt = word_cnt;
    if (clear) begin
      word_cnt_nxt = '0;
    end else if (word_done) begin
      word_cnt_nxt = last_word ? '0 : word_cnt + NUM_WORDS_BIT'(1);
    end
  end

  // Outputs are registered from next-cycle values so they line up with state.
  // Ready is also offered during the last beat of any word but the final one,
  // which lets back-to-back words stream without a bubble.
  assign write_nxt = (state_nxt == ST_WRITE);
  assign ready_nxt = (state_nxt == ST_FETCH) ||
                     (write_nxt && last_byte_next &&
                      (word_cnt_nxt != NUM_WORDS_BIT'(NUM_WORDS - 1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      word_cnt         <= '0;
      addr_reg         <= '0;
      bus.mem_addr     <= '0;
      bus.mem_wr_en    <= 1'b0;
      bus.result_ready <= 1'b0;
      busy_wb_dma      <= 1'b0;
      done_wb_dma      <= 1'b0;
    end else begin
      state            <= state_nxt;
      word_cnt         <= word_cnt_nxt;
      bus.mem_wr_en    <= write_nxt;
      bus.result_ready <= ready_nxt;
      busy_wb_dma      <= (state_nxt == ST_FETCH) || write_nxt;
      done_wb_dma      <= (state_nxt == ST_DONE);
      // addr_reg is the address of the next beat; it wraps silently.
      if (state == ST_IDLE && en_wb_dma) begin
        addr_reg <= wb_base_address;
      end else if (write_nxt) begin
        bus.mem_addr <= addr_reg;
        addr_reg     <= addr_reg + BUS_ADDR_WIDTH'(1);
      end
    end
  end

  assign bus.mem_data_wr = byte_out;

endmodule

// File: tb/tb_naive_wb_dma.sv
// Directed plus randomized bench for naive_wb_dma with a byte-stream reference
// model: transfer byte i goes to base+i and is byte (i mod BYTES) of word i/BYTES.
module tb_naive_wb_dma;
  import naive_wb_dma_pkg::*;

  localparam int WW    = 32;
  localparam int BW    = 8;
  localparam int AW    = 32;
  localparam int NW    = 4;
  localparam int NWB   = 2;
  localparam int BYTES = WW / BW;

  logic          clk;
  logic          rst;
  logic          en;
  logic [AW-1:0] base;
  logic          done;
  logic          busy;
  logic [1:0]    state_dbg;

  naive_wb_dma_if #(.WORD_WIDTH(WW), .BUS_DATA_WIDTH(BW), .BUS_ADDR_WIDTH(AW)) bus ();

  naive_wb_dma #(
    .WORD_WIDTH     (WW),
    .BUS_DATA_WIDTH (BW),
    .BUS_ADDR_WIDTH (AW),
    .NUM_WORDS      (NW),
    .NUM_WORDS_BIT  (NWB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en_wb_dma       (en),
    .wb_base_address (base),
    .done_wb_dma     (done),
    .busy_wb_dma     (busy),
    .state_dbg       (state_dbg),
    .bus             (bus)
  );

  int                 n_asserts = 0;
  int                 n_fail    = 0;
  logic [AW+BW-1:0]   exp_q[$];
  logic [WW-1:0]      src_q[$];
  int                 cyc = 0;
  int                 wr_count = 0;
  int                 last_wr_cyc = -1;
  int                 first_wr_cyc = -1;
  logic [AW+BW-1:0]   first_wr_val = '0;
  int                 first_accept_cyc = -1;
  int                 done_rise_cyc = -1;
  int                 done_rises = 0;
  int                 gap_lo = 0;
  int                 gap_hi = 0;

  // ---------------- clock / reset block ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- source driver ----------------
  // Decides at each negedge; a handshake predicted there completes at the next posedge.
  initial begin
    int   gap;
    logic fire;
    gap  = 0;
    fire = 1'b0;
    bus.result_valid = 1'b0;
    bus.result_data  = '0;
    forever begin
      @(negedge clk);
      if (fire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        gap = int'($urandom_range(gap_hi, gap_lo));
      end
      if (src_q.size() > 0 && gap == 0) begin
        bus.result_valid = 1'b1;
        bus.result_data  = src_q[0];
      end else begin
        bus.result_valid = 1'b0;
        bus.result_data  = $urandom;
        if (gap > 0) gap--;
      end
      fire = bus.result_valid && bus.result_ready;
      if (fire && first_accept_cyc < 0) first_accept_cyc = cyc;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [AW+BW-1:0] e;
    logic             done_prev;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("write_addr_data", {bus.mem_addr, bus.mem_data_wr}, e);
        end
        if (first_wr_cyc < 0) begin
          first_wr_cyc = cyc;
          first_wr_val = {bus.mem_addr, bus.mem_data_wr};
        end
        wr_count++;
        last_wr_cyc = cyc;
      end
      if (done === 1'b1 && done_prev !== 1'b1) begin
        done_rises++;
        done_rise_cyc = cyc;
      end
      done_prev = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_xfer(input logic [AW-1:0] b, input logic [WW-1:0] w [NW], input int n_exp);
    logic [WW-1:0] wd;
    logic [BW-1:0] by;
    for (int i = 0; i < n_exp; i++) begin
      wd = w[i / BYTES];
      by = BW'(wd >> (BW * (BYTES - 1 - (i % BYTES))));
      exp_q.push_back({b + AW'(i), by});
    end
    for (int i = 0; i < NW; i++) src_q.push_back(w[i]);
    first_wr_cyc     = -1;
    first_accept_cyc = -1;
    done_rise_cyc    = -1;
  endtask

  task automatic full_xfer(input string tag, input logic [AW-1:0] b, input logic [WW-1:0] w [NW],
                           input int span_exp);
    int wr0;
    wr0 = wr_count;
    load_xfer(b, w, NW * BYTES);
    base = b;
    en   = 1'b1;
    for (int k = 0; k < 400 && done !== 1'b1; k++) tick();
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_nwrites"}, wr_count - wr0, NW * BYTES);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_done_latency"}, done_rise_cyc, last_wr_cyc + 1);
    check({tag, "_first_latency"}, first_wr_cyc, first_accept_cyc + 1);
    check({tag, "_busy_in_done"}, busy, 1'b0);
    if (span_exp >= 0) check({tag, "_write_span"}, last_wr_cyc - first_wr_cyc, span_exp);
  endtask

  task automatic end_xfer();
    en = 1'b0;
    tick();
    tick();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [WW-1:0] words [NW];
    logic [WW-1:0] rnd   [NW];
    int            wr0;
    int            rises0;

    rst  = 1'b1;
    en   = 1'b0;
    base = '0;
    repeat (3) tick();
    check("rst_wr_en", bus.mem_wr_en, 1'b0);
    check("rst_addr", bus.mem_addr, '0);
    check("rst_data", bus.mem_data_wr, '0);
    check("rst_ready", bus.result_ready, 1'b0);
    check("rst_done_busy", {done, busy}, 2'b00);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    tick();

    // Basic transfer with the source always valid: 16 beats, no gaps.
    words[0] = 32'h1234_5678;
    words[1] = 32'h9abc_def0;
    words[2] = 32'h0fde_cba9;
    words[3] = 32'h8765_4321;
    gap_lo = 0; gap_hi = 0;
    full_xfer("basic", 32'h0000_0100, words, NW * BYTES - 1);
    check("basic_first_beat", first_wr_val, {32'h0000_0100, 8'h12});

    // Done handshake: enable held high keeps done up with no new writes.
    wr0 = wr_count;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("done_hold", {done, busy, bus.mem_wr_en}, 3'b100);
    end
    check("done_hold_no_writes", wr_count - wr0, 0);
    en = 1'b0;
    tick();
    check("done_release_state", state_dbg, ST_IDLE);
    check("done_release_done", done, 1'b0);
    tick();

    // Restart at a new base after the handshake.
    for (int i = 0; i < NW; i++) rnd[i] = $urandom;
    full_xfer("restart", 32'h0000_2000 + AW'($urandom_range(255, 0)), rnd, NW * BYTES - 1);
    end_xfer();

    // Source stalls: valid low long enough that 3 empty bus cycles appear between words.
    gap_lo = 6; gap_hi = 6;
    full_xfer("stall", 32'h0000_0100, words, NW * BYTES - 1 + 3 * (NW - 1));
    end_xfer();
    gap_lo = 0; gap_hi = 0;

    // Abort after the 2nd beat of word 1: six beats written, no done.
    wr0    = wr_count;
    rises0 = done_rises;
    for (int i = 0; i < NW; i++) rnd[i] = $urandom;
    load_xfer(32'h0000_4000, rnd, BYTES + 2);
    base = 32'h0000_4000;
    en   = 1'b1;
    for (int k = 0; k < 200 && (wr_count - wr0) < BYTES + 2; k++) tick();
    en = 1'b0;
    src_q.delete();
    tick();
    check("abort_wr_en_drop", bus.mem_wr_en, 1'b0);
    check("abort_state", state_dbg, ST_IDLE);
    repeat (6) tick();
    check("abort_nwrites", wr_count - wr0, BYTES + 2);
    check("abort_no_done", done_rises - rises0, 0);
    check("abort_exp_empty", exp_q.size(), 0);

    // Restart from base 0 after the abort: begins at word 0 byte 0x12.
    full_xfer("abort_restart", 32'h0000_0000, words, NW * BYTES - 1);
    check("abort_restart_first", first_wr_val, {32'h0000_0000, 8'h12});
    end_xfer();

    // Address wrap.
    for (int i = 0; i < NW; i++) rnd[i] = $urandom;
    full_xfer("wrap", 32'hffff_fffe, rnd, NW * BYTES - 1);
    end_xfer();

    // Reset in the middle of a word.
    wr0 = wr_count;
    for (int i = 0; i < NW; i++) rnd[i] = $urandom;
    load_xfer(32'h0000_8000, rnd, 2);
    base = 32'h0000_8000;
    en   = 1'b1;
    for (int k = 0; k < 200 && (wr_count - wr0) < 2; k++) tick();
    rst = 1'b1;
    en  = 1'b0;
    src_q.delete();
    tick();
    check("midrst_outputs", {bus.mem_wr_en, bus.result_ready, done, busy}, 4'b0000);
    check("midrst_addr_data", {bus.mem_addr, bus.mem_data_wr}, '0);
    check("midrst_state", state_dbg, ST_IDLE);
    rst = 1'b0;
    repeat (5) tick();
    check("midrst_no_writes", wr_count - wr0, 2);
    check("midrst_exp_empty", exp_q.size(), 0);

    // Randomized transfers with random stalls.
    gap_lo = 0; gap_hi = 7;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NW; i++) rnd[i] = $urandom;
      full_xfer("random", $urandom, rnd, -1);
      end_xfer();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/naive_wb_dma.md
Name: naive_wb_dma

Overview:
Write-back DMA, the memory-write counterpart of the weight-load path of naive_DMA. It accepts result words, either CIM column outputs or softmax outputs, over a valid/ready handshake. Each word is serialized MSB-byte-first onto the byte-wide memory bus at incrementing addresses. It signals completion to the controller with a level handshake.

Parameters:
WORD_WIDTH, 32, width of one result word.
BUS_DATA_WIDTH, 8, memory bus data width; WORD_WIDTH must be an integer multiple of it.
BUS_ADDR_WIDTH, 32, memory address width.
NUM_WORDS, 4, words per transfer.
NUM_WORDS_BIT, 2, width of the word counter; holds values 0..NUM_WORDS-1.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
en_wb_dma  in  1  start / keep-alive level from the controller
wb_base_address  in  BUS_ADDR_WIDTH  first byte address; sampled at start
done_wb_dma  out  1  transfer complete; held until en_wb_dma falls
busy_wb_dma  out  1  high in FETCH and WRITE
result_data  in  WORD_WIDTH  result word from CIM or softmax
result_valid  in  1  result_data is valid
result_ready  out  1  DMA accepts result_data this cycle
mem_data_wr  out  BUS_DATA_WIDTH  write data
mem_addr  out  BUS_ADDR_WIDTH  write address
mem_wr_en  out  1  write strobe; memory accepts every strobed cycle

Behaviour:
- Derived constant: BYTES = WORD_WIDTH/BUS_DATA_WIDTH.
- All state updates are on the posedge of clk. All outputs are registered.
- Reset values: all outputs are 0, the state is IDLE, and all counters are 0. rst is effective in any state, including mid-transfer.
- State IDLE:
  - If en_wb_dma=1, latch wb_base_address into addr_reg and go to FETCH.
  - Otherwise stay in IDLE.
- State FETCH:
  - result_ready=1.
  - On result_valid && result_ready: load the word into the shift register, set byte_cnt=0, go to WRITE.
- State WRITE:
  - Each cycle: mem_wr_en=1, mem_data_wr = upper BUS_DATA_WIDTH bits of the shift register, mem_addr = addr_reg.
  - Each cycle after the write: shift the register left by BUS_DATA_WIDTH, increment addr_reg, increment byte_cnt.
  - addr_reg wraps modulo 2^BUS_ADDR_WIDTH with no error.
- Overlap rule:
  - During the cycle with byte_cnt==BYTES-1 and word_cnt!=NUM_WORDS-1, result_ready=1.
  - If a word is accepted in that cycle, reload the shift register and stay in WRITE with byte_cnt=0. There is no bubble, giving a sustained rate of BYTES cycles per word.
  - If no word is accepted, go to FETCH.
- Word counting: word_cnt increments on each completed word.
- Last byte of word NUM_WORDS-1: go to DONE; word_cnt returns to 0.
- State DONE:
  - done_wb_dma=1, mem_wr_en=0, result_ready=0.
  - Stay in DONE while en_wb_dma=1. Go to IDLE when en_wb_dma=0, so a held enable never restarts a transfer.
- Latency:
  - The word accepted at cycle t has its first byte on the bus with mem_wr_en high at cycle t+1, and its last byte at t+BYTES.
  - done_wb_dma rises the cycle after the final byte.
- Abort: en_wb_dma=0 in FETCH or WRITE returns to IDLE next cycle.
  - mem_wr_en drops in that same cycle.
  - The partial word is discarded, done is not asserted, and counters clear.
- Simultaneous events: a start while in DONE is impossible (en must fall first). result_valid outside FETCH, and outside the overlap cycle, is ignored without being consumed.
- Byte order is big-endian: word 32'h1234_5678 writes 12, 34, 56, 78 at addresses A, A+1, A+2, A+3.
- mem_data_wr and mem_addr hold their last values when mem_wr_en=0; they are don't-care to the memory.

Decomposition:
- Shared package: state encoding (IDLE, FETCH, WRITE, DONE) and the BYTES derivation, shared with naive_DMA's load path.
- One sub-module: word_serializer, containing the shift register, byte counter, load and last-byte flags. The FSM, word counter and address counter stay in the top module.

Test Plan:
- Basic transfer:
  - Stimulus: reset; en=1, base=0x100; result_valid always 1, words 32'h1234_5678, 32'h9abc_def0, 32'h0fde_cba9, 32'h8765_4321.
  - Response: 16 consecutive writes, bytes 12 34 56 78 9a bc de f0 0f de cb a9 87 65 43 21 at addresses 0x100..0x10F with no gaps. done rises the next cycle; busy is 0 in DONE.
- Source stalls:
  - Stimulus: result_valid low for 3 cycles between words.
  - Response: mem_wr_en is 0 during the gaps, byte/address sequence identical to the basic transfer, no byte dropped or duplicated.
- Done handshake:
  - Stimulus: hold en high 5 cycles after done.
  - Response: done stays high and no new writes occur. After en falls, state returns to IDLE; en high again restarts at the new base.
- Abort:
  - Stimulus: drop en after the 2nd byte of word 1.
  - Response: mem_wr_en is 0 the next cycle and done never asserts. A restart with base=0x0 writes from word 0 with byte 12 at address 0.
- Address wrap:
  - Stimulus: base=0xFFFF_FFFE.
  - Response: addresses FFFF_FFFE, FFFF_FFFF, 0000_0000, 0000_0001, ...
- Reset mid-WRITE:
  - Stimulus: assert rst for 1 cycle mid-word.
  - Response: the next cycle all outputs are 0 and the state is IDLE; no further writes until en is reasserted.
